// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types and constants for the five-stage MIPS core.
//   regdst_t   : destination-register select carried down the pipe
//   memtoreg_t : write-data select carried down the pipe
//   wbstate_t  : writeback-stage run/flush/halt state
//   REG_RA     : link register used by JAL
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RD   = 2'b00,
        RT   = 2'b01,
        RA   = 2'b10,
        NONE = 2'b11
    } regdst_t;

    typedef enum logic [1:0] {
        ALU  = 2'b00,
        LOAD = 2'b01,
        NPC  = 2'b10,
        ALU2 = 2'b11
    } memtoreg_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        FLUSH  = 2'b01,
        HALTED = 2'b10
    } wbstate_t;

    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// Final stage of the five-stage MIPS core. Selects register-file write data
// and destination from the MEM/WB latch, drives the register-file write port,
// keeps a one-entry bypass copy of the last committed write, counts retired
// instructions, and on HALT runs a flush handshake with the data cache before
// raising a sticky halted flag.
//
// Ports
//   CLK, RST                 : clock, asynchronous active-high reset
//   wb_valid, RegW, Mem,
//   RegDest, rd, rt,
//   alu_out, dload, npc,
//   halt_in                  : MEM/WB latch contents
//   WEN, wsel, wdat          : register-file write port (combinational)
//   byp_valid/sel/dat        : last committed write (registered)
//   flush_req, flush_done    : data-cache flush handshake
//   halted                   : core halted (sticky until reset)
//   retired                  : retired-instruction counter, wraps
// -----------------------------------------------------------------------------
module writeback_stage
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wb_valid,
    input  logic             RegW,
    input  logic [1:0]       Mem,
    input  logic [1:0]       RegDest,
    input  logic [31:0]      rd,
    input  logic [31:0]      rt,
    input  logic [31:0]      alu_out,
    input  logic [31:0]      dload,
    input  logic [31:0]      npc,
    input  logic             halt_in,
    output logic             WEN,
    output logic [4:0]       wsel,
    output logic [31:0]      wdat,
    output logic             byp_valid,
    output logic [4:0]       byp_sel,
    output logic [31:0]      byp_dat,
    output logic             flush_req,
    input  logic             flush_done,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    wbstate_t         r_state;
    wbstate_t         w_state_nxt;

    logic             r_byp_valid;
    logic [4:0]       r_byp_sel;
    logic [31:0]      r_byp_dat;
    logic [CNT_W-1:0] r_retired;

    logic [4:0]       w_wsel;
    logic [31:0]      w_wdat;
    logic             w_run;
    logic             w_wen;
    logic             w_retire;

    // Only the low five bits of the register-number fields are meaningful.
    logic             w_unused;
    assign w_unused = ^{rd[31:5], rt[31:5]};

    // ---------------------------------------------------------------------
    // Destination and write-data selection (active in every state; WEN is
    // the only thing that gates the register-file write).
    // ---------------------------------------------------------------------
    always_comb begin
        w_wsel = 5'd0;
        case (regdst_t'(RegDest))
            RD:      w_wsel = rd[4:0];
            RT:      w_wsel = rt[4:0];
            RA:      w_wsel = REG_RA;
            default: w_wsel = 5'd0;   // NONE: $0 target, write suppressed below
        endcase
    end

    always_comb begin
        w_wdat = alu_out;
        case (memtoreg_t'(Mem))
            LOAD:    w_wdat = dload;
            NPC:     w_wdat = npc;
            default: w_wdat = alu_out; // ALU and ALU2 both take the ALU result
        endcase
    end

    assign w_run    = (r_state == RUN);
    // HALT itself never writes; $0 is hardwired so writes to it are dropped.
    assign w_wen    = wb_valid & RegW & ~halt_in & (w_wsel != 5'd0) & w_run;
    // HALT counts as retired, bubbles do not.
    assign w_retire = wb_valid & w_run;

    // ---------------------------------------------------------------------
    // Halt FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (wb_valid && halt_in) w_state_nxt = FLUSH;
            FLUSH:   if (flush_done)          w_state_nxt = HALTED;
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = RUN;
        endcase
    end

    // ---------------------------------------------------------------------
    // Bypass register: holds the last committed write until overwritten.
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_byp_valid <= 1'b0;
            r_byp_sel   <= 5'd0;
            r_byp_dat   <= 32'd0;
        end else if (w_wen) begin
            r_byp_valid <= 1'b1;
            r_byp_sel   <= w_wsel;
            r_byp_dat   <= w_wdat;
        end
    end

    // ---------------------------------------------------------------------
    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // ---------------------------------------------------------------------
    // Outputs. flush_req/halted decode the state register directly so they
    // drop as soon as the asynchronous reset hits the state flop.
    // ---------------------------------------------------------------------
    assign WEN       = w_wen;
    assign wsel      = w_wsel;
    assign wdat      = w_wdat;
    assign byp_valid = r_byp_valid;
    assign byp_sel   = r_byp_sel;
    assign byp_dat   = r_byp_dat;
    assign flush_req = (r_state == FLUSH);
    assign halted    = (r_state == HALTED);
    assign retired   = r_retired;

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the five-stage MIPS core. It consumes the MEM/WB latch outputs, selects register-file write data and destination, and drives the register-file write port. It also holds a one-entry bypass register of the last committed write and counts retired instructions. On HALT it runs a drain/flush handshake with the data cache before asserting a sticky `halted`.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `CLK`  in  1: core clock; all state updates on the rising edge.
- `RST`  in  1: reset, asynchronous, active-high.
- `wb_valid`  in  1: the MEM/WB latch holds a real instruction (0 = bubble).
- `RegW`  in  1: the instruction writes a register.
- `Mem`  in  2: write-data select.
- `RegDest`  in  2: destination select.
- `rd`, `rt`  in  32 each: register numbers; only bits [4:0] are used.
- `alu_out`, `dload`, `npc`  in  32 each: ALU result, load data, and PC+4.
- `halt_in`  in  1: the instruction is HALT.
- `WEN`  out  1: register-file write enable.
- `wsel`  out  5: register-file write index.
- `wdat`  out  32: register-file write data.
- `byp_valid`, `byp_sel[4:0]`, `byp_dat[31:0]`  out: last committed write, for the decode-stage bypass.
- `flush_req`  out  1: request to the data cache to write back dirty lines.
- `flush_done`  in  1: the cache reports that the flush is complete.
- `halted`  out  1: the core has halted (sticky).
- `retired`  out  `CNT_W`: count of retired instructions.

## Operation
- **Destination (`RegDest`):**
  - 00 → `rd[4:0]`
  - 01 → `rt[4:0]`
  - 10 → 31
  - 11 → 0, which suppresses the write
- **Write data (`Mem`):**
  - 00 → `alu_out`
  - 01 → `dload`
  - 10 → `npc`
  - 11 → `alu_out`
- **Write enable:** `WEN = wb_valid & RegW & ~halt_in & (wsel != 0) & (state == RUN)`.
  - `wsel` and `wdat` are driven from the selects in every state; only `WEN` gates the write.
- **FSM states:** RUN, FLUSH, HALTED.
  - RUN → FLUSH when `wb_valid & halt_in`.
  - FLUSH → HALTED when `flush_done`.
  - HALTED is terminal until reset.
- **Inputs outside RUN:** in FLUSH and HALTED, all MEM/WB inputs are ignored: no writes, no counting.
- **`flush_req`:** equals `(state == FLUSH)`.
- **`halted`:** equals `(state == HALTED)`.
- **Bypass register:** loads `{1, wsel, wdat}` on every cycle where `WEN = 1`. It otherwise holds its value and is never cleared except by reset.
- **Retire counter:** increments by 1 on every RUN cycle with `wb_valid = 1`, HALT included. Bubbles are not counted. It wraps from 2^CNT_W−1 to 0.

## Timing
- **Reset values:**
  - state = RUN
  - `byp_valid` = 0, `byp_sel` = 0, `byp_dat` = 0
  - `retired` = 0
  - `flush_req` = 0, `halted` = 0
  - `WEN` is 0 whenever `wb_valid` = 0
- **Write path:** combinational from the MEM/WB outputs, zero latency. The register file captures the write on the same `CLK` edge.
- **Bypass path:** `byp_*` reflect a write one cycle after its `WEN` cycle.
- **HALT sequence:**
  - HALT is present in cycle N.
  - `flush_req` rises at N+1.
  - `flush_done` is sampled only in FLUSH. If it is high in cycle M, `halted` = 1 and `flush_req` = 0 from M+1.
  - Minimum HALT-to-`halted` latency is 2 cycles.
- **`flush_done` outside FLUSH:** ignored in RUN and HALTED.
- **`retired`:** registered; it shows the updated count one cycle after the retiring instruction.
- **Reset during FLUSH or HALTED:** asynchronously returns to RUN. `flush_req` and `halted` drop immediately, without waiting for a clock edge.

## Structure
- `cpu_types_pkg` gains:
  - `regdst_t` enum: RD, RT, RA, NONE
  - `memtoreg_t` enum: ALU, LOAD, NPC, ALU2
  - `wbstate_t` enum: RUN, FLUSH, HALTED
  - constant `REG_RA = 5'd31`
- The stage is a single module with no sub-modules.

## Test plan
- **ALU write:** `wb_valid=1, RegW=1, RegDest=00, rd=5, Mem=00, alu_out=0xDEADBEEF` → same cycle `WEN=1, wsel=5, wdat=0xDEADBEEF`; next cycle `byp_valid=1, byp_sel=5, byp_dat=0xDEADBEEF`; `retired=1`.
- **JAL and load write:**
  - JAL: `RegDest=10, Mem=10, npc=0x104` → `wsel=31, wdat=0x104`.
  - Load: `RegDest=01, rt=9, Mem=01, dload=0x55` → `wsel=9, wdat=0x55`.
- **`$0` suppression and bubble:**
  - Write to `rd=0` → `WEN=0`, bypass unchanged, `retired` still increments.
  - Bubble (`wb_valid=0`) → `WEN=0`, `retired` unchanged.
- **HALT flush:**
  - HALT in cycle 10 with `RegW=1` → `WEN=0` in cycle 10; `flush_req=1` in cycles 11–13.
  - `flush_done=1` in cycle 13 → `halted=1, flush_req=0` from cycle 14.
  - Later `RegW` stimulus produces no writes and no counting.
- **Async reset during FLUSH:** assert `RST` mid-cycle in FLUSH → `flush_req=0, halted=0, retired=0, byp_valid=0` before the next edge; the next valid ALU write commits normally.
- **Counter wrap:** `CNT_W=4`, 17 valid instructions → `retired=1`.
